// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - Single-byte I2C master (address + one write or read byte) with open-drain SCL/SDA
//
// Purpose : Issues START, 7-bit address + R/W, checks the address ACK, then either
//           writes one byte (and checks its ACK) or reads one byte (and answers with
//           a master NACK), and finishes with STOP. Each bit-time is split into four
//           quarters of CLK_DIV clk cycles.
// Build   : define I2C_MASTER_CLKSTRETCH_EN to let a slave stretch SCL. The quarter
//           counter then waits in Q1 while released SCL still reads low.
// Ports   : clk      - system clock, rising edge
//           reset    - asynchronous, active-high
//           start    - transaction request, sampled only while idle
//           rw       - 1 = read, 0 = write
//           addr     - 7-bit slave address
//           wdata    - byte to write
//           rdata    - last byte read
//           busy     - high from start accept until back in IDLE
//           done     - one-cycle pulse on return to IDLE
//           ack_err  - address or write byte was NACKed in the last transaction
//           scl, sda - open-drain bus lines (driven 0 or released)

module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        scl,
    inout  wire        sda
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_MNACK, S_STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     r_state;
    logic [7:0] r_div;
    logic [1:0] r_q;
    logic [2:0] r_bit;
    logic [7:0] r_abyte;
    logic [7:0] r_wbyte;
    logic [7:0] r_rx;
    logic [7:0] r_rdata;
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;
    logic       r_scl_low;
    logic       r_sda_low;

    logic       w_sda_in;
    logic       w_hold;
    logic       w_q_end;
    logic       w_bit_end;
    logic       w_smp;
    state_t     w_nx_state;
    state_t     w_o_state;
    logic [2:0] w_nx_bit;
    logic [2:0] w_o_bit;
    logic [1:0] w_o_q;
    logic [7:0] w_o_byte;
    logic [1:0] w_drive;

    // State that follows the current one at the end of its bit-time.
    function automatic state_t next_state(input state_t s, input logic [2:0] b,
                                          input logic nack, input logic rd);
        state_t n;
        n = S_IDLE;
        case (s)
            S_START: n = S_ADDR;
            S_ADDR:  n = (b == 3'd0) ? S_AACK : S_ADDR;
            S_AACK:  n = nack ? S_STOP : (rd ? S_READ : S_WRITE);
            S_WRITE: n = (b == 3'd0) ? S_WACK : S_WRITE;
            S_WACK:  n = S_STOP;
            S_READ:  n = (b == 3'd0) ? S_MNACK : S_READ;
            S_MNACK: n = S_STOP;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // Line levels for a given state/quarter: {scl_low, sda_low}.
    function automatic logic [1:0] line_drive(input state_t s, input logic [1:0] q,
                                              input logic bitv);
        logic scl_low;
        logic sda_low;
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (s)
            S_START: sda_low = q[1];
            S_ADDR, S_WRITE: begin
                scl_low = (q == 2'd0) || (q == 2'd3);
                sda_low = !bitv;
            end
            S_AACK, S_WACK, S_READ, S_MNACK:
                scl_low = (q == 2'd0) || (q == 2'd3);
            S_STOP: begin
                scl_low = (q == 2'd0);
                sda_low = !q[1];
            end
            default: ;
        endcase
        return {scl_low, sda_low};
    endfunction

    assign scl      = r_scl_low ? 1'b0 : 1'bz;
    assign sda      = r_sda_low ? 1'b0 : 1'bz;
    assign w_sda_in = sda;

`ifdef I2C_MASTER_CLKSTRETCH_EN
    logic w_scl_in;
    assign w_scl_in = scl;
    // Only a line we have released can be held low by the slave.
    assign w_hold   = (r_state != S_IDLE) && (r_q == 2'd1) && !r_scl_low && !w_scl_in;
`else
    assign w_hold   = 1'b0;
`endif

    assign w_q_end   = (r_state != S_IDLE) && !w_hold && (r_div == DIV_LAST);
    assign w_bit_end = w_q_end && (r_q == 2'd3);
    assign w_smp     = w_q_end && (r_q == 2'd1);   // edge that enters Q2

    assign w_nx_state = next_state(r_state, r_bit, r_ack_err, r_abyte[0]);

    always_comb begin
        w_nx_bit = r_bit;
        if (w_nx_state != r_state) begin
            if (w_nx_state inside {S_ADDR, S_WRITE, S_READ})
                w_nx_bit = 3'd7;
        end else if (r_bit != 3'd0) begin
            w_nx_bit = r_bit - 3'd1;
        end
    end

    // Line levels are computed for the quarter about to start so the pins come
    // straight from flops and never glitch on a state change.
    assign w_o_state = w_bit_end ? w_nx_state : r_state;
    assign w_o_bit   = w_bit_end ? w_nx_bit : r_bit;
    assign w_o_q     = r_q + 2'd1;
    assign w_o_byte  = (w_o_state == S_WRITE) ? r_wbyte : r_abyte;
    assign w_drive   = line_drive(w_o_state, w_o_q, w_o_byte[w_o_bit]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= 8'd0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_abyte   <= 8'd0;
            r_wbyte   <= 8'd0;
            r_rx      <= 8'd0;
            r_rdata   <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_scl_low <= 1'b0;
            r_sda_low <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                // A start coinciding with the done pulse is dropped.
                if (start && !r_done) begin
                    r_state   <= S_START;
                    r_busy    <= 1'b1;
                    r_ack_err <= 1'b0;
                    r_abyte   <= {addr, rw};
                    r_wbyte   <= wdata;
                    r_div     <= 8'd0;
                    r_q       <= 2'd0;
                    r_bit     <= 3'd0;
                    r_scl_low <= 1'b0;
                    r_sda_low <= 1'b0;
                end
            end else begin
                if (!w_hold) begin
                    if (r_div == DIV_LAST) begin
                        r_div                  <= 8'd0;
                        r_q                    <= w_o_q;
                        {r_scl_low, r_sda_low} <= w_drive;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                if (w_smp) begin
                    if ((r_state == S_AACK || r_state == S_WACK) && w_sda_in)
                        r_ack_err <= 1'b1;
                    if (r_state == S_READ)
                        r_rx <= {r_rx[6:0], w_sda_in};
                end
                if (w_bit_end) begin
                    r_state <= w_nx_state;
                    r_bit   <= w_nx_bit;
                    if (r_state == S_MNACK)
                        r_rdata <= r_rx;
                    if (r_state == S_STOP) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign rdata   = r_rdata;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - Directed self-checking bench for i2c_master with a behavioural slave

module tb_i2c_master;

    logic       clk;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    wire  [7:0] rdata;
    wire        busy;
    wire        done;
    wire        ack_err;
    wire        scl_w;
    wire        sda_w;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int stop_base = 0;

    // Behavioural slave / bus monitor state
    logic       s_sda_low  = 1'b0;
    logic       s_scl_low  = 1'b0;
    logic       s_ack_addr = 1'b1;
    logic       s_ack_data = 1'b1;
    logic [7:0] s_rbyte    = 8'h00;
    logic [7:0] b0 = 8'h00;
    logic [7:0] b1 = 8'h00;
    logic       a0 = 1'b0;
    logic       a1 = 1'b0;
    int         k = 0;
    int         stop_cnt = 0;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = s_sda_low ? 1'b0 : 1'bz;
    assign scl_w = s_scl_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl_w),
        .sda     (sda_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rises 1-8 address byte, 9 its ACK, 10-17 data byte, 18 its ACK / master NACK.
    always @(scl_w or sda_w) begin
        if (scl_w !== p_scl) begin
            if (scl_w === 1'b1) begin
                k++;
                if (k <= 8)       b0 = {b0[6:0], sda_w};
                else if (k == 9)  a0 = sda_w;
                else if (k <= 17) b1 = {b1[6:0], sda_w};
                else if (k == 18) a1 = sda_w;
            end else begin
                if (k == 8)
                    s_sda_low = s_ack_addr;
                else if (k == 9)
                    s_sda_low = b0[0] ? ~s_rbyte[7] : 1'b0;
                else if (k >= 10 && k <= 16 && b0[0])
                    s_sda_low = ~s_rbyte[16 - k];
                else if (k == 17)
                    s_sda_low = b0[0] ? 1'b0 : s_ack_data;
                else
                    s_sda_low = 1'b0;
            end
        end else if (sda_w !== p_sda && scl_w === 1'b1) begin
            if (sda_w === 1'b0) k = 0;
            else stop_cnt++;
        end
        p_scl = scl_w;
        p_sda = sda_w;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_wdata);
        rw        = i_rw;
        addr      = i_addr;
        wdata     = i_wdata;
        start     = 1'b1;
        stop_base = stop_cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts clk edges after the accept edge until done; optionally drives start or
    // stretches SCL between edges p_on and p_off. n = -1 on timeout.
    task automatic wait_done(input int p_on, input int p_off, input logic use_scl, output int cnt);
        cnt = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (i == p_on) begin
                if (use_scl) s_scl_low = 1'b1; else start = 1'b1;
            end
            if (i == p_off) begin
                if (use_scl) s_scl_low = 1'b0; else start = 1'b0;
            end
            if (done === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rw    = 1'b0;
        addr  = 7'h00;
        wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata",   rdata,   8'h00);
        check("rst_scl",     scl_w,   1);
        check("rst_sda",     sda_w,   1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Write 0xA5 to 0x2A, both bytes ACKed
        go(1'b0, 7'h2A, 8'hA5);
        check("wr_busy", busy, 1);
        wait_done(-1, -1, 1'b0, n);
        check("wr_cycles",   n,       320);
        check("wr_addrbyte", b0,      8'h54);
        check("wr_databyte", b1,      8'hA5);
        check("wr_aack",     a0,      0);
        check("wr_wack",     a1,      0);
        check("wr_ack_err",  ack_err, 0);
        check("wr_busy_end", busy,    0);
        check("wr_stop",     stop_cnt - stop_base, 1);
        @(posedge clk); #1;
        check("wr_done_pulse", done, 0);

        // Read from 0x2A, slave returns 0x3C
        s_rbyte = 8'h3C;
        go(1'b1, 7'h2A, 8'h00);
        wait_done(-1, -1, 1'b0, n);
        check("rd_cycles",   n,       320);
        check("rd_addrbyte", b0,      8'h55);
        check("rd_busbyte",  b1,      8'h3C);
        check("rd_rdata",    rdata,   8'h3C);
        check("rd_mnack",    a1,      1);
        check("rd_ack_err",  ack_err, 0);
        @(posedge clk); #1;

        // Address NACK
        s_ack_addr = 1'b0;
        go(1'b0, 7'h2A, 8'hA5);
        wait_done(-1, -1, 1'b0, n);
        check("nack_cycles",  n,       176);
        check("nack_ack_err", ack_err, 1);
        check("nack_aack",    a0,      1);
        check("nack_stop",    stop_cnt - stop_base, 1);
        check("nack_rdata",   rdata,   8'h3C);
        s_ack_addr = 1'b1;
        @(posedge clk); #1;

        // ack_err clears on accept; inputs latched; start while busy and on done ignored
        go(1'b0, 7'h2A, 8'h96);
        check("clr_ack_err", ack_err, 0);
        addr  = 7'h11;
        wdata = 8'h00;
        rw    = 1'b1;
        wait_done(50, 51, 1'b0, n);
        check("busy_cycles",   n,  320);
        check("latch_addr",    b0, 8'h54);
        check("latch_wdata",   b1, 8'h96);
        rw    = 1'b0;
        addr  = 7'h2A;
        wdata = 8'h5A;
        start = 1'b1;
        @(posedge clk); #1;
        check("start_on_done_ignored", busy, 0);
        @(posedge clk); #1;
        check("start_after_done_accepted", busy, 1);
        start = 1'b0;
        wait_done(-1, -1, 1'b0, n);
        check("b2b_cycles", n,  320);
        check("b2b_wdata",  b1, 8'h5A);
        @(posedge clk); #1;

        // Reset during WRITE bit 4 (data bit 0 driven, SCL low in Q0)
        go(1'b0, 7'h2A, 8'hA5);
        repeat (208) @(posedge clk);
        #1;
        check("pre_rst_scl",  scl_w, 0);
        check("pre_rst_sda",  sda_w, 0);
        check("pre_rst_busy", busy,  1);
        reset = 1'b1;
        #1;
        check("mid_rst_scl",   scl_w, 1);
        check("mid_rst_sda",   sda_w, 1);
        check("mid_rst_busy",  busy,  0);
        check("mid_rst_rdata", rdata, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", busy,  0);
        check("post_rst_scl",  scl_w, 1);
        go(1'b0, 7'h2A, 8'hA5);
        wait_done(-1, -1, 1'b0, n);
        check("post_rst_cycles",   n,       320);
        check("post_rst_addrbyte", b0,      8'h54);
        check("post_rst_databyte", b1,      8'hA5);
        check("post_rst_ack_err",  ack_err, 0);
        @(posedge clk); #1;

`ifdef I2C_MASTER_CLKSTRETCH_EN
        // Slave holds SCL low for 10 cycles of Q1 in ADDR bit 3
        go(1'b0, 7'h2A, 8'hA5);
        wait_done(81, 94, 1'b1, n);
        check("stretch_cycles",   n,  330);
        check("stretch_addrbyte", b0, 8'h54);
        check("stretch_databyte", b1, 8'hA5);
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period, legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  transaction request; sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  transferred R/W bit: 1 = read, 0 = write.
REQ-006 SHALL have port addr  input  7  slave address, sent MSB first.
REQ-007 SHALL have port wdata  input  8  write byte, sent MSB first.
REQ-008 SHALL have port rdata  output  8  last byte read.
REQ-009 SHALL have port busy  output  1  high from the start-accept edge until return to IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse on return to IDLE.
REQ-011 SHALL have port ack_err  output  1  high when the last transaction saw a NACK on the address or write byte.
REQ-012 SHALL have ports scl and sda  inout  1 each  open-drain: driven 0 or released (z), never driven 1.

Function
REQ-013 SHALL latch rw, addr and wdata on the start-accept edge; later input changes SHALL have no effect on the current transaction.
REQ-014 SHALL divide each bit-time into quarters Q0..Q3 of CLK_DIV cycles each.
- Q0: SCL low; SDA changes.
- Q1, Q2: SCL released.
- Q3: SCL low.
- SDA is sampled on entry to Q2.
REQ-015 SHALL implement the states IDLE, START, ADDR, AACK, WRITE, WACK, READ, MNACK, STOP.
REQ-016 START: SDA and SCL released in Q0-Q1; SDA low in Q2-Q3 with SCL released, so SDA falls while SCL is high.
REQ-017 ADDR SHALL send 8 bits: addr[6:0] then rw. AACK SHALL release SDA and sample it.
- Sampled 0 (ACK): go to WRITE if rw = 0, READ if rw = 1.
- Sampled 1 (NACK): set ack_err, go to STOP.
REQ-018 WRITE SHALL send wdata[7:0]. WACK SHALL sample SDA; a NACK sets ack_err. Both outcomes go to STOP.
REQ-019 READ SHALL release SDA and shift in 8 bits MSB first. MNACK SHALL release SDA (master NACK) for 1 bit-time. rdata SHALL update at the end of MNACK.
REQ-020 STOP: SDA low in Q0-Q1, SCL released from Q1; SDA released in Q2-Q3, so SDA rises while SCL is high. Then go to IDLE and pulse done.
REQ-021 Each transaction SHALL be exactly 20 bit-times (80*CLK_DIV clk cycles) from the start-accept edge to done, or 11 bit-times (44*CLK_DIV) on an address NACK.
REQ-022 ack_err SHALL clear on the next start accept.
REQ-023 start while busy SHALL be ignored. start on the cycle done is high SHALL be ignored; start one cycle later SHALL be accepted.
REQ-024 The bit counter SHALL count 7..0 and SHALL NOT wrap; on reaching 0 the state SHALL advance.

Reset
REQ-025 On reset, SHALL within the same cycle (asynchronously):
- release scl and sda;
- enter IDLE;
- drive busy = 0, done = 0, ack_err = 0, rdata = 8'h00;
- clear the divider and bit counter.
REQ-026 Reset mid-transaction SHALL abort with no STOP issued. After reset deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-027 With macro I2C_MASTER_CLKSTRETCH_EN defined, SHALL sample the SCL line in Q1 and hold the quarter counter while released SCL reads 0, supporting slave clock stretching. The 20-bit-time timing then becomes a minimum.
REQ-028 Without I2C_MASTER_CLKSTRETCH_EN, the SCL input SHALL be ignored and timing SHALL be exactly per REQ-021.

Verification
REQ-029 Write: CLK_DIV = 4, addr = 7'h2A, rw = 0, wdata = 8'hA5, slave ACKs both bytes -> bus carries 0x54 then 0xA5, done at cycle 320, ack_err = 0.
REQ-030 Read: addr = 7'h2A, rw = 1, slave returns 8'h3C -> address byte 0x55, rdata = 8'h3C, SDA released in MNACK, done at cycle 320.
REQ-031 Address NACK: slave silent -> ack_err = 1, STOP issued, done at cycle 176.
REQ-032 Reset asserted in bit 4 of WRITE -> scl and sda read z and busy = 0 in the same cycle; the next transaction completes normally.
REQ-033 start pulsed while busy and on the done cycle -> both ignored; start one cycle after done -> accepted.
REQ-034 With I2C_MASTER_CLKSTRETCH_EN, slave holds SCL low 10 cycles in ADDR bit 3 -> done at cycle 330, data intact.
